// File: rtl/llc_mem_responder.sv
// llc_mem_responder
// Memory-side endpoint for the LLC memory request/response channel.
// Requests are queued in a 2-entry FIFO and executed strictly in order
// against a private line-granular backing store after a fixed access
// latency. Writes commit silently; reads return one line on the response
// channel and hold it until the consumer accepts it.
//
// Ports
//   clk, rst             : clock, asynchronous active-low reset
//   llc_mem_req_*        : request channel (valid/ready, hwrite, hsize,
//                          hprot, line address, write line)
//   llc_mem_rsp_*        : read response channel (valid/ready, line)
//   busy                 : FIFO holds a request or an op is in flight
//   rd_cnt, wr_cnt       : saturating completed-read / committed-write counts

module llc_mem_responder #(
    parameter int LINE_BITS = 128,
    parameter int ADDR_BITS = 28,
    parameter int MEM_LINES = 1024,
    parameter int LATENCY   = 4,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 llc_mem_req_valid,
    output logic                 llc_mem_req_ready,
    input  logic                 llc_mem_req_hwrite,
    input  logic [2:0]           llc_mem_req_hsize,
    input  logic [1:0]           llc_mem_req_hprot,
    input  logic [ADDR_BITS-1:0] llc_mem_req_addr,
    input  logic [LINE_BITS-1:0] llc_mem_req_line,
    output logic                 llc_mem_rsp_valid,
    input  logic                 llc_mem_rsp_ready,
    output logic [LINE_BITS-1:0] llc_mem_rsp_line,
    output logic                 busy,
    output logic [CNT_BITS-1:0]  rd_cnt,
    output logic [CNT_BITS-1:0]  wr_cnt
);

    localparam int IDX_BITS   = $clog2(MEM_LINES);
    localparam int ENTRY_BITS = 1 + IDX_BITS + LINE_BITS;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Request FIFO
    logic [ENTRY_BITS-1:0] fifoMem_q [2];
    logic                  wrPtr_q;
    logic                  rdPtr_q;
    logic [1:0]            fifoCount_q;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  push;
    logic                  pop;

    // Operation engine
    state_t                state_q;
    logic [7:0]            cnt_q;
    logic                  opWrite_q;
    logic [IDX_BITS-1:0]   opIdx_q;
    logic [LINE_BITS-1:0]  opLine_q;
    logic                  rspValid_q;
    logic [LINE_BITS-1:0]  rspLine_q;
    logic [CNT_BITS-1:0]   rdCnt_q;
    logic [CNT_BITS-1:0]   wrCnt_q;
    logic [CNT_BITS-1:0]   rdCnt_d;
    logic [CNT_BITS-1:0]   wrCnt_d;
    logic                  memWe;

    logic [LINE_BITS-1:0]  mem [MEM_LINES];

    // Size, protection and the aliased upper address bits are trace-only.
    logic unusedBits;
    assign unusedBits = ^{llc_mem_req_hsize, llc_mem_req_hprot,
                          llc_mem_req_addr[ADDR_BITS-1:IDX_BITS]};

    assign fifoFull  = (fifoCount_q == 2'd2);
    assign fifoEmpty = (fifoCount_q == 2'd0);
    // Ready looks only at the registered occupancy, so a full FIFO stays
    // closed even in the cycle its head is being popped.
    assign push      = llc_mem_req_valid && !fifoFull;
    assign pop       = (state_q == IDLE) && !fifoEmpty;

    assign rdCnt_d = (rdCnt_q == {CNT_BITS{1'b1}}) ? rdCnt_q : rdCnt_q + CNT_BITS'(1);
    assign wrCnt_d = (wrCnt_q == {CNT_BITS{1'b1}}) ? wrCnt_q : wrCnt_q + CNT_BITS'(1);

    // A write commits on the last WAIT cycle, so the next dequeue (at least
    // one IDLE cycle later) always sees it without any forwarding.
    assign memWe = (state_q == WAIT) && (cnt_q == 8'd0) && opWrite_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q     <= 1'b0;
            rdPtr_q     <= 1'b0;
            fifoCount_q <= 2'd0;
        end else begin
            if (push) begin
                wrPtr_q <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            case ({push, pop})
                2'b10:   fifoCount_q <= fifoCount_q + 2'd1;
                2'b01:   fifoCount_q <= fifoCount_q - 2'd1;
                default: fifoCount_q <= fifoCount_q;
            endcase
        end
    end

    // FIFO payload carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {llc_mem_req_hwrite,
                                   llc_mem_req_addr[IDX_BITS-1:0],
                                   llc_mem_req_line};
        end
    end

    // Backing store is deliberately not reset.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[opIdx_q] <= opLine_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            opWrite_q  <= 1'b0;
            opIdx_q    <= '0;
            opLine_q   <= '0;
            rspValid_q <= 1'b0;
            rspLine_q  <= '0;
            rdCnt_q    <= '0;
            wrCnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifoEmpty) begin
                        {opWrite_q, opIdx_q, opLine_q} <= fifoMem_q[rdPtr_q];
                        cnt_q   <= LAT_M1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else if (opWrite_q) begin
                        wrCnt_q <= wrCnt_d;
                        state_q <= IDLE;
                    end else begin
                        rspLine_q  <= mem[opIdx_q];
                        rspValid_q <= 1'b1;
                        rdCnt_q    <= rdCnt_d;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (llc_mem_rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign llc_mem_req_ready = !fifoFull;
    assign llc_mem_rsp_valid = rspValid_q;
    assign llc_mem_rsp_line  = rspLine_q;
    assign busy              = !fifoEmpty || (state_q != IDLE);
    assign rd_cnt            = rdCnt_q;
    assign wr_cnt            = wrCnt_q;

endmodule

// File: tb/tb_llc_mem_responder.sv
// tb_llc_mem_responder
// Self-checking bench for llc_mem_responder. A behavioural model keeps the
// expected memory image (indexed by address modulo MEM_LINES), an ordered
// queue of expected read data and plain integer op counts; responses are
// compared on every handshake. Directed sequences cover latency, FIFO
// backpressure, response stall, aliasing, reset mid-write and counter
// saturation; a randomized phase follows.

module tb_llc_mem_responder;

    localparam int LINE_BITS = 128;
    localparam int ADDR_BITS = 28;
    localparam int MEM_LINES = 1024;
    localparam int LATENCY   = 4;
    localparam int CNT_BITS  = 6;
    localparam int CNT_MAX   = (1 << CNT_BITS) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 reqValid = 1'b0;
    logic                 reqReady;
    logic                 reqWrite = 1'b0;
    logic [2:0]           reqSize = 3'd0;
    logic [1:0]           reqProt = 2'd0;
    logic [ADDR_BITS-1:0] reqAddr = '0;
    logic [LINE_BITS-1:0] reqLine = '0;
    logic                 rspValid;
    logic                 rspReady = 1'b1;
    logic [LINE_BITS-1:0] rspLine;
    logic                 busy;
    logic [CNT_BITS-1:0]  rdCnt;
    logic [CNT_BITS-1:0]  wrCnt;

    int checkCount = 0;
    int passCount  = 0;

    logic [LINE_BITS-1:0] modelMem [int];
    logic [LINE_BITS-1:0] expQ [$];
    int                   pool [$];
    int                   modelRd = 0;
    int                   modelWr = 0;
    bit                   rspRandom = 1'b0;
    bit                   rspHold = 1'b1;

    llc_mem_responder #(
        .LINE_BITS(LINE_BITS),
        .ADDR_BITS(ADDR_BITS),
        .MEM_LINES(MEM_LINES),
        .LATENCY(LATENCY),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .llc_mem_req_valid(reqValid),
        .llc_mem_req_ready(reqReady),
        .llc_mem_req_hwrite(reqWrite),
        .llc_mem_req_hsize(reqSize),
        .llc_mem_req_hprot(reqProt),
        .llc_mem_req_addr(reqAddr),
        .llc_mem_req_line(reqLine),
        .llc_mem_rsp_valid(rspValid),
        .llc_mem_rsp_ready(rspReady),
        .llc_mem_rsp_line(rspLine),
        .busy(busy),
        .rd_cnt(rdCnt),
        .wr_cnt(wrCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [LINE_BITS-1:0] observed,
                               input logic [LINE_BITS-1:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [LINE_BITS-1:0] expCnt(input int n);
        return LINE_BITS'((n > CNT_MAX) ? CNT_MAX : n);
    endfunction

    function automatic logic [LINE_BITS-1:0] randLine();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Response ready is updated just after each rising edge, after the main
    // process has had its chance to change the hold/random controls.
    always begin
        @(posedge clk);
        #2;
        rspReady = rspRandom ? 1'($urandom_range(0, 1)) : rspHold;
    end

    // Handshakes are judged mid-cycle, where valid, ready and line are stable.
    always @(negedge clk) begin
        if (rst && rspValid && rspReady) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRsp", LINE_BITS'(1), LINE_BITS'(0));
            end else begin
                checkOutput("rspLine", rspLine, expQ.pop_front());
            end
        end
    end

    // Presents one request and returns one tick after the accepting edge.
    // With track set, the model applies the request in order at acceptance.
    task automatic applyStimulus(input logic wr, input logic [ADDR_BITS-1:0] addr,
                                 input logic [LINE_BITS-1:0] line, input bit track);
        int waitCycles = 0;
        int idx;
        reqValid = 1'b1;
        reqWrite = wr;
        reqAddr  = addr;
        reqLine  = line;
        reqSize  = 3'($urandom);
        reqProt  = 2'($urandom);
        while (!reqReady && waitCycles < 200) begin
            @(posedge clk);
            #1;
            waitCycles++;
        end
        if (!reqReady) begin
            checkOutput("reqTimeout", LINE_BITS'(0), LINE_BITS'(1));
            reqValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        if (track) begin
            idx = int'(addr) % MEM_LINES;
            if (wr) begin
                modelMem[idx] = line;
                modelWr++;
            end else begin
                expQ.push_back(modelMem.exists(idx) ? modelMem[idx] : '0);
                modelRd++;
            end
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || rspValid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("quiesce", LINE_BITS'(busy || rspValid), LINE_BITS'(0));
        checkOutput("pendingRsp", LINE_BITS'(expQ.size()), LINE_BITS'(0));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Ready"}, LINE_BITS'(reqReady), LINE_BITS'(1));
        checkOutput({tag, "RspValid"}, LINE_BITS'(rspValid), LINE_BITS'(0));
        checkOutput({tag, "RspLine"}, rspLine, LINE_BITS'(0));
        checkOutput({tag, "Busy"}, LINE_BITS'(busy), LINE_BITS'(0));
        checkOutput({tag, "RdCnt"}, LINE_BITS'(rdCnt), LINE_BITS'(0));
        checkOutput({tag, "WrCnt"}, LINE_BITS'(wrCnt), LINE_BITS'(0));
    endtask

    initial begin
        logic [LINE_BITS-1:0] patA5;
        logic [LINE_BITS-1:0] lineX;
        logic [LINE_BITS-1:0] lineY;
        int lat;
        int n;
        int idx;

        patA5 = {4{32'hA5A5_A5A5}};

        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Write then read 0x10; read valid expected LATENCY+1 edges after accept.
        applyStimulus(1'b1, 28'h10, patA5, 1'b1);
        checkOutput("busyAfterAccept", LINE_BITS'(busy), LINE_BITS'(1));
        waitIdle();
        checkOutput("wrCntFirst", LINE_BITS'(wrCnt), expCnt(modelWr));
        applyStimulus(1'b0, 28'h10, '0, 1'b1);
        lat = 0;
        while (!rspValid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("readLatency", LINE_BITS'(lat), LINE_BITS'(LATENCY + 1));
        waitIdle();
        checkOutput("rdCntFirst", LINE_BITS'(rdCnt), expCnt(modelRd));
        checkOutput("rspLineHeld", rspLine, patA5);
        checkOutput("busyIdle", LINE_BITS'(busy), LINE_BITS'(0));

        // Two writes to 0x3 then a read: FIFO is full while the first write waits.
        applyStimulus(1'b1, 28'h3, LINE_BITS'(32'h1111), 1'b1);
        applyStimulus(1'b1, 28'h3, LINE_BITS'(32'h2222), 1'b1);
        applyStimulus(1'b0, 28'h3, '0, 1'b1);
        for (int i = 0; i <= LATENCY; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            checkOutput("readyFullWindow", LINE_BITS'(reqReady), LINE_BITS'(i == LATENCY));
        end
        waitIdle();

        // Stalled response: line stable, FIFO fills, third request held off.
        rspHold = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 28'h10, '0, 1'b1);
        n = 0;
        while (!rspValid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("stallValid", LINE_BITS'(rspValid), LINE_BITS'(1));
        lineX = randLine();
        applyStimulus(1'b1, 28'h20, lineX, 1'b1);
        applyStimulus(1'b0, 28'h20, '0, 1'b1);
        reqValid = 1'b1;
        reqWrite = 1'b0;
        reqAddr  = 28'h10;
        for (int i = 0; i < 8; i++) begin
            checkOutput("stallReady", LINE_BITS'(reqReady), LINE_BITS'(0));
            checkOutput("stallRspValid", LINE_BITS'(rspValid), LINE_BITS'(1));
            checkOutput("stallRspLine", rspLine, expQ[0]);
            @(posedge clk);
            #1;
        end
        rspHold = 1'b1;
        applyStimulus(1'b0, 28'h10, '0, 1'b1);
        waitIdle();

        // Aliasing: 0x405 maps onto index 0x005.
        lineX = randLine();
        applyStimulus(1'b1, 28'h005, lineX, 1'b1);
        applyStimulus(1'b0, 28'h405, '0, 1'b1);
        waitIdle();

        // Reset during WAIT of a write: old contents survive, state is cleared.
        lineY = randLine();
        applyStimulus(1'b1, 28'h7, lineY, 1'b1);
        waitIdle();
        applyStimulus(1'b1, 28'h7, ~lineY, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        expQ.delete();
        modelRd = 0;
        modelWr = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkResetState("midReset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 28'h7, '0, 1'b1);
        waitIdle();
        checkOutput("rdCntAfterReset", LINE_BITS'(rdCnt), expCnt(modelRd));
        checkOutput("wrCntAfterReset", LINE_BITS'(wrCnt), expCnt(modelWr));

        // Saturation: more writes than the counter can represent.
        for (int i = 0; i < CNT_MAX + 8; i++) begin
            idx = int'($urandom_range(0, 63));
            pool.push_back(idx);
            applyStimulus(1'b1, ADDR_BITS'(idx), randLine(), 1'b1);
        end
        waitIdle();
        checkOutput("wrCntSaturated", LINE_BITS'(wrCnt), LINE_BITS'(CNT_MAX));
        checkOutput("wrCntModel", LINE_BITS'(wrCnt), expCnt(modelWr));

        // Randomized mix with random response backpressure and idle gaps.
        rspRandom = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 1) == 1) begin
                idx = int'($urandom_range(0, 63));
                pool.push_back(idx);
                applyStimulus(1'b1, ADDR_BITS'(idx + ($urandom_range(0, 255) << 10)),
                              randLine(), 1'b1);
            end else begin
                idx = pool[$urandom_range(0, pool.size() - 1)];
                applyStimulus(1'b0, ADDR_BITS'(idx + ($urandom_range(0, 255) << 10)),
                              '0, 1'b1);
            end
        end
        waitIdle();
        rspRandom = 1'b0;
        checkOutput("rdCntFinal", LINE_BITS'(rdCnt), expCnt(modelRd));
        checkOutput("wrCntFinal", LINE_BITS'(wrCnt), expCnt(modelWr));

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/llc_mem_responder.md
Name: llc_mem_responder

Overview:
- Memory-side responder for the LLC memory request/response channel. Receives line read/write requests and returns line read data on the memory response channel.
- Serves as the main-memory endpoint for LLC unit/system benches and as the template for the SoC memory-controller shim.
- Holds a private line-granular backing store, applies a programmable fixed access latency, and strictly preserves request order.

Parameters:
- LINE_BITS, 128, width of one cache line (words per line × word width)
- ADDR_BITS, 28, width of the line address carried on the request
- MEM_LINES, 1024, backing-store depth in lines; must be a power of 2; IDX_BITS = log2(MEM_LINES)
- LATENCY, 4, cycles from request dequeue to completion; legal range 1..255
- CNT_BITS, 16, width of the statistics counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- llc_mem_req_valid  in  1  request valid
- llc_mem_req_ready  out  1  request ready; equals request FIFO not full
- llc_mem_req_hwrite  in  1  1 = write line, 0 = read line
- llc_mem_req_hsize  in  3  access size; carried for tracing, not used functionally
- llc_mem_req_hprot  in  2  protection bits; carried for tracing, not used functionally
- llc_mem_req_addr  in  ADDR_BITS  line address
- llc_mem_req_line  in  LINE_BITS  write data; ignored on reads
- llc_mem_rsp_valid  out  1  read response valid
- llc_mem_rsp_ready  in  1  read response ready
- llc_mem_rsp_line  out  LINE_BITS  read data
- busy  out  1  FIFO non-empty or FSM not in IDLE
- rd_cnt  out  CNT_BITS  completed reads, saturating
- wr_cnt  out  CNT_BITS  committed writes, saturating

Behaviour:
- Reset values:
  - llc_mem_req_ready = 1; llc_mem_rsp_valid = 0; llc_mem_rsp_line = 0.
  - busy = 0; rd_cnt = 0; wr_cnt = 0.
  - FIFO empty; FSM in IDLE; latency counter = 0.
  - Backing-store contents are not reset (undefined until written).
- Request FIFO:
  - 2 entries; each entry stores {hwrite, addr[IDX_BITS-1:0], line}.
  - Push when valid && ready.
  - ready is deasserted while the FIFO is full, even in a cycle where a pop occurs (no full-bypass).
  - Address bits at and above IDX_BITS are ignored, so addresses alias modulo MEM_LINES.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the current-op register, load cnt = LATENCY-1, go to WAIT. The pop and a push may occur in the same cycle.
  - WAIT: if cnt != 0, decrement cnt; if cnt == 0, complete the op:
    - Write: store the line to mem[idx]; wr_cnt++; go to IDLE.
    - Read: latch mem[idx] into llc_mem_rsp_line; assert llc_mem_rsp_valid next cycle; rd_cnt++; go to RESP.
  - RESP: hold valid and line stable until llc_mem_rsp_ready. On the handshake cycle, drop valid next cycle and go to IDLE. A stalled response blocks further dequeues, and the FIFO backpressures once full.
- Timing:
  - Request accepted at cycle T with the FSM idle and the FIFO empty (the FIFO registers the request): dequeue at T+1.
  - Read: llc_mem_rsp_valid high at T+1+LATENCY.
  - Write: committed at the end of cycle T+LATENCY, i.e. visible to a read dequeued at T+LATENCY+1 or later.
  - Back-to-back throughput: one op per LATENCY+1 cycles for writes; LATENCY+2 cycles for reads with ready held high.
- Ordering: strict FIFO order; a read following a write to the same index always returns the new data. No forwarding path from the FIFO is needed because the write commits before the next dequeue.
- Counters saturate at 2^CNT_BITS-1; they do not wrap.
- busy = !fifo_empty || state != IDLE.
- Reset mid-operation: the FIFO, FSM and an in-flight response are discarded; the pending write is not committed; counters are cleared.
- llc_mem_rsp_line holds its last value when valid is low.

Test Plan:
- Reset, then write addr 0x10 line 0xA5A5_..., then read 0x10 (LATENCY=4) -> rsp_valid 1 at accept+5, line 0xA5A5_...; wr_cnt=1, rd_cnt=1, busy returns to 0.
- Write 0x3 = 0x1111, immediately write 0x3 = 0x2222, then read 0x3 back-to-back -> response 0x2222; ready drops for exactly the cycles where the FIFO holds 2 entries.
- Read pending with llc_mem_rsp_ready held low for 10 cycles while pushing 3 more requests -> line stable all 10 cycles; the 3rd push is stalled (ready=0) until the handshake.
- Aliasing with MEM_LINES=1024: write addr 0x005 = X, read addr 0x405 -> returns X.
- Assert rst low in WAIT of a write to 0x7 (previously Y) -> after reset, read 0x7 returns Y; counters read 0.
- 2^16+5 writes with CNT_BITS=16 -> wr_cnt = 0xFFFF, no wrap; LATENCY=1 back-to-back reads -> valid at accept+2, one read completes every 3 cycles.
